// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage feeding decode.
// Owns the PC, issues one 32-bit read at a time on the instruction bus and
// buffers fetched {pc, inst} pairs in a small in-order queue drained by
// decode over valid/ready. A redirect flushes the queue and retargets the PC;
// a read still in flight at that point completes on the bus and its data is
// discarded.
//
// Handshake semantics: the decode side transfers the queue head on any cycle
// where out_valid && out_ready. out_valid depends only on the queue count, so
// it never depends combinationally on out_ready. On the bus side ireq_valid and
// ireq_addr are held stable from request until iresp_addr_ok.
//
// Optional build macro FETCH_PERF_EN adds the stall_cnt output, a saturating
// count of cycles in which nothing is offered to decode.
//
// dbg_state exposes the fetch FSM state (0 idle, 1 address, 2 data).

module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0] stall_cnt,
`endif
  output logic [1:0]  dbg_state
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [63:0]     pc_q;
  logic [63:0]     req_addr;
  logic            discard;
  logic [CW-1:0]   count;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [31:0]     inst_mem [QDEPTH];
  logic [63:0]     pc_mem   [QDEPTH];

  logic            data_fire;
  logic            issue;
  logic            push;
  logic            pop;

  // Redirect targets are word aligned; the low bits carry no information.
  logic [1:0]      redirect_lsb_unused;
  assign redirect_lsb_unused = redirect_pc[1:0];

  // Bus events and queue strobes; a redirect overrides push, pop and issue.
  always_comb begin
    data_fire = ((state == S_ADDR) && iresp_addr_ok && iresp_data_ok) ||
                ((state == S_DATA) && iresp_data_ok);
    issue     = (state == S_IDLE) && !redirect_valid && (count < CW'(QDEPTH));
    push      = data_fire && !discard && !redirect_valid;
    pop       = out_valid && out_ready && !redirect_valid;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: at most one request outstanding on the bus.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (issue) state_nxt = S_ADDR;
      S_ADDR: if (iresp_addr_ok) state_nxt = iresp_data_ok ? S_IDLE : S_DATA;
      S_DATA: if (iresp_data_ok) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM and queue outputs; empty queue presents zeros toward decode.
  always_comb begin
    ireq_valid = (state == S_ADDR);
    ireq_addr  = ireq_valid ? req_addr : 64'd0;
    out_valid  = (count != '0);
    out_inst   = out_valid ? inst_mem[head] : 32'd0;
    out_pc     = out_valid ? pc_mem[head]   : 64'd0;
    dbg_state  = state;
  end

  // PC, request address and discard tracking for in-flight reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      req_addr <= 64'd0;
      discard  <= 1'b0;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[63:2], 2'b00};
      if (data_fire)             discard <= 1'b0;
      else if (state != S_IDLE)  discard <= 1'b1;
    end else begin
      if (issue) req_addr <= pc_q;
      if (data_fire) begin
        if (discard) discard <= 1'b0;
        else         pc_q    <= pc_q + 64'd4;
      end
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (redirect_valid) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail] <= iresp_data;
      pc_mem[tail]   <= req_addr;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating count of cycles with nothing offered to decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               stall_cnt <= 32'd0;
    else if (!out_valid && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
`endif

  // Bus data: either a fixed function of the requested address or a
  // hand-driven word.
  logic        bus_auto;
  logic [31:0] man_data;
  assign iresp_data = bus_auto ? (ireq_addr[31:0] ^ 32'h1357_9BDF) : man_data;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
`ifdef FETCH_PERF_EN
    .stall_cnt      (stall_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    bus_auto       = 1'b0;
    man_data       = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    out_ready      = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    step();
    step();
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    step();
    checks++;
    if ({ireq_valid, ireq_addr, out_valid, out_inst, out_pc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b a=%h ov=%0b i=%h pc=%h want all zero",
               ireq_valid, ireq_addr, out_valid, out_inst, out_pc);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    end
`endif
  endtask

  task automatic test_stream();
    logic [95:0] exp_q[$];
    logic [95:0] exp;
    do_reset();
    bus_auto = 1'b1; iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; out_ready = 1'b1;
    exp_q.push_back({64'h0000_0000_8000_0000, 32'h9357_9BDF});
    exp_q.push_back({64'h0000_0000_8000_0004, 32'h9357_9BDB});
    exp_q.push_back({64'h0000_0000_8000_0008, 32'h9357_9BD7});
    exp_q.push_back({64'h0000_0000_8000_000C, 32'h9357_9BD3});
    while (exp_q.size() != 0) begin
      step();
      exp = exp_q[0];
      checks++;
      if ({ireq_valid, ireq_addr} !== {1'b1, exp[95:32]}) begin
        errors++;
        $display("FAIL stream_req: got v=%0b a=%h want v=1 a=%h", ireq_valid, ireq_addr, exp[95:32]);
      end
      step();
      exp = exp_q.pop_front();
      checks++;
      if ({out_valid, out_pc, out_inst} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL stream_out: got v=%0b pc=%h i=%h want v=1 pc=%h i=%h",
                 out_valid, out_pc, out_inst, exp[95:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus_auto = 1'b1; iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; out_ready = 1'b0;
    repeat (4) step();
    checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 64'h0000_0000_8000_0000, 32'h9357_9BDF}) begin
      errors++;
      $display("FAIL bp_head: got v=%0b pc=%h i=%h want v=1 pc=80000000 i=93579bdf",
               out_valid, out_pc, out_inst);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({ireq_valid, out_pc} !== {1'b0, 64'h0000_0000_8000_0000}) begin
        errors++;
        $display("FAIL bp_full_hold: got v=%0b pc=%h want v=0 pc=80000000", ireq_valid, out_pc);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid, out_pc, out_inst, ireq_valid} !==
        {1'b1, 64'h0000_0000_8000_0004, 32'h9357_9BDB, 1'b0}) begin
      errors++;
      $display("FAIL bp_drain2: got v=%0b pc=%h i=%h req=%0b want v=1 pc=80000004 i=93579bdb req=0",
               out_valid, out_pc, out_inst, ireq_valid);
    end
    step();
    checks++;
    if ({out_valid, ireq_valid, ireq_addr} !== {1'b0, 1'b1, 64'h0000_0000_8000_0008}) begin
      errors++;
      $display("FAIL bp_resume: got ov=%0b req=%0b a=%h want ov=0 req=1 a=80000008",
               out_valid, ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_addr_stall();
    do_reset();
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ireq_valid, ireq_addr, out_valid} !== {1'b1, 64'h0000_0000_8000_0000, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got v=%0b a=%h ov=%0b want v=1 a=80000000 ov=0",
                 i, ireq_valid, ireq_addr, out_valid);
      end
      if (i < 2) step();
    end
    iresp_addr_ok = 1'b1;
    step();
    checks++;
    if ({ireq_valid, dbg_state, out_valid} !== {1'b0, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL stall_data_wait: got v=%0b st=%0d ov=%0b want v=0 st=2 ov=0",
               ireq_valid, dbg_state, out_valid);
    end
    iresp_addr_ok = 1'b0; iresp_data_ok = 1'b1; man_data = 32'hDEAD_0001;
    step();
    iresp_data_ok = 1'b0;
    checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 64'h0000_0000_8000_0000, 32'hDEAD_0001}) begin
      errors++;
      $display("FAIL stall_push: got v=%0b pc=%h i=%h want v=1 pc=80000000 i=dead0001",
               out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_redirect_data();
    do_reset();
    out_ready = 1'b1;
    step();
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_1002;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if ({ireq_valid, out_valid, dbg_state} !== {1'b0, 1'b0, 2'd2}) begin
      errors++;
      $display("FAIL redir_wait: got v=%0b ov=%0b st=%0d want v=0 ov=0 st=2",
               ireq_valid, out_valid, dbg_state);
    end
    iresp_data_ok = 1'b1; man_data = 32'hCAFE_0000;
    step();
    iresp_data_ok = 1'b0;
    checks++;
    if ({out_valid, ireq_valid} !== 2'b00) begin
      errors++;
      $display("FAIL redir_drop: got ov=%0b v=%0b want ov=0 v=0", out_valid, ireq_valid);
    end
    step();
    checks++;
    if ({ireq_valid, ireq_addr} !== {1'b1, 64'h0000_0000_8000_1000}) begin
      errors++;
      $display("FAIL redir_target: got v=%0b a=%h want v=1 a=80001000", ireq_valid, ireq_addr);
    end
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; man_data = 32'h1111_2222;
    step();
    checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 64'h0000_0000_8000_1000, 32'h1111_2222}) begin
      errors++;
      $display("FAIL redir_first: got v=%0b pc=%h i=%h want v=1 pc=80001000 i=11112222",
               out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    out_ready = 1'b0;
    step();
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; man_data = 32'hBAD0_BAD0;
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_9000_0007;
    step();
    iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0; redirect_valid = 1'b0;
    checks++;
    if ({out_valid, ireq_valid} !== 2'b00) begin
      errors++;
      $display("FAIL same_drop: got ov=%0b v=%0b want ov=0 v=0", out_valid, ireq_valid);
    end
    step();
    checks++;
    if ({ireq_valid, ireq_addr} !== {1'b1, 64'h0000_0000_9000_0004}) begin
      errors++;
      $display("FAIL same_target: got v=%0b a=%h want v=1 a=90000004", ireq_valid, ireq_addr);
    end
    iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; man_data = 32'h55AA_55AA;
    step();
    checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 64'h0000_0000_9000_0004, 32'h55AA_55AA}) begin
      errors++;
      $display("FAIL same_kept: got v=%0b pc=%h i=%h want v=1 pc=90000004 i=55aa55aa",
               out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    bus_auto = 1'b1; iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; out_ready = 1'b0;
    repeat (4) step();
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_2000;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({out_valid, ireq_valid} !== 2'b00) begin
      errors++;
      $display("FAIL full_flush: got ov=%0b v=%0b want ov=0 v=0", out_valid, ireq_valid);
    end
    step();
    checks++;
    if ({ireq_valid, ireq_addr, out_valid} !== {1'b1, 64'h0000_0000_8000_2000, 1'b0}) begin
      errors++;
      $display("FAIL full_refetch: got v=%0b a=%h ov=%0b want v=1 a=80002000 ov=0",
               ireq_valid, ireq_addr, out_valid);
    end
    step();
    checks++;
    if ({out_valid, out_pc, out_inst} !== {1'b1, 64'h0000_0000_8000_2000, 32'h9357_BBDF}) begin
      errors++;
      $display("FAIL full_new_head: got v=%0b pc=%h i=%h want v=1 pc=80002000 i=9357bbdf",
               out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_auto = 1'b1; iresp_addr_ok = 1'b1; iresp_data_ok = 1'b1; out_ready = 1'b0;
    repeat (3) step();
    iresp_addr_ok = 1'b0; iresp_data_ok = 1'b0;
    checks++;
    if ({ireq_valid, ireq_addr, out_valid} !== {1'b1, 64'h0000_0000_8000_0004, 1'b1}) begin
      errors++;
      $display("FAIL mid_pre: got v=%0b a=%h ov=%0b want v=1 a=80000004 ov=1",
               ireq_valid, ireq_addr, out_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({ireq_valid, ireq_addr, out_valid, out_inst, out_pc, dbg_state} !== '0) begin
      errors++;
      $display("FAIL mid_async: got v=%0b a=%h ov=%0b i=%h pc=%h st=%0d want all zero",
               ireq_valid, ireq_addr, out_valid, out_inst, out_pc, dbg_state);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL mid_stall_zero: got %0d want 0", stall_cnt);
    end
`endif
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({ireq_valid, ireq_addr} !== {1'b1, 64'h0000_0000_8000_0000}) begin
      errors++;
      $display("FAIL mid_restart: got v=%0b a=%h want v=1 a=80000000", ireq_valid, ireq_addr);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (stall_cnt !== 32'd1) begin
      errors++;
      $display("FAIL mid_stall_one: got %0d want 1", stall_cnt);
    end
    step();
    checks++;
    if (stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL mid_stall_two: got %0d want 2", stall_cnt);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_addr_stall();
    test_redirect_data();
    test_redirect_same_cycle();
    test_redirect_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
